// File: rtl/house_keys_pkg.sv
// Shared keypad definitions: key indices, key count, debounce FSM states
// and the lowest-index key selector used for n-key lockout.
package house_keys_pkg;

  localparam int unsigned NUM_KEYS = 12;

  localparam logic [3:0] KEY_0     = 4'd0;
  localparam logic [3:0] KEY_1     = 4'd1;
  localparam logic [3:0] KEY_2     = 4'd2;
  localparam logic [3:0] KEY_3     = 4'd3;
  localparam logic [3:0] KEY_4     = 4'd4;
  localparam logic [3:0] KEY_5     = 4'd5;
  localparam logic [3:0] KEY_6     = 4'd6;
  localparam logic [3:0] KEY_7     = 4'd7;
  localparam logic [3:0] KEY_8     = 4'd8;
  localparam logic [3:0] KEY_9     = 4'd9;
  localparam logic [3:0] KEY_ENTER = 4'd10;
  localparam logic [3:0] KEY_CLEAR = 4'd11;

  typedef enum logic [1:0] {
    KP_IDLE      = 2'd0,
    KP_PRESS_DEB = 2'd1,
    KP_HELD      = 2'd2,
    KP_REL_DEB   = 2'd3
  } kp_state_t;

  // Index of the lowest set key; 0 when no key is set.
  function automatic logic [3:0] lowest_key(input logic [NUM_KEYS-1:0] keys);
    logic [3:0] idx;
    idx = '0;
    for (int unsigned i = NUM_KEYS; i > 0; i--) begin
      if (keys[i-1]) idx = 4'(i - 1);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_sync.sv
// Two-flop synchroniser for asynchronous key lines, synchronous active-low reset.
module keypad_sync #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  // Two-stage capture of the raw levels.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/keypad_pulse_encoder.sv
// Keypad front-end: synchronise, debounce with n-key lockout, and emit one
// registered one-cycle pulse plus key code per accepted press.
// Optional build macro KEYPAD_AUTOREPEAT_EN adds auto-repeat for digit keys.
module keypad_pulse_encoder
  import house_keys_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [NUM_KEYS-1:0] key_raw,
  output logic [NUM_KEYS-1:0] key_pulse,
  output logic                key_valid,
  output logic [3:0]          key_code,
  output logic                key_held
);

  localparam int unsigned W_CNT = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam logic [W_CNT-1:0] CNT_END = W_CNT'(DEBOUNCE_CYCLES);

  if (DEBOUNCE_CYCLES == 0 || REPEAT_DELAY == 0 || REPEAT_PERIOD == 0) begin : g_param_check
    $error("keypad_pulse_encoder: timing parameters must be at least 1");
  end

  logic [NUM_KEYS-1:0] w_sync;
  logic [3:0]          w_sel;
  logic                w_cand_hi;
  logic                w_cnt_done;
  logic                w_fire_press;
  logic                w_fire_rep;
  logic                w_fire;
  logic                w_held;
  kp_state_t           r_state;
  kp_state_t           w_state_nxt;
  logic [W_CNT-1:0]    r_cnt;
  logic [3:0]          r_cand;
  logic [NUM_KEYS-1:0] r_pulse;
  logic [3:0]          r_code;

  keypad_sync #(
    .WIDTH (NUM_KEYS)
  ) u_sync (
    .i_clk   (CLK),
    .i_rst_n (RST),
    .i_d     (key_raw),
    .o_q     (w_sync)
  );

  assign w_sel      = lowest_key(w_sync);
  assign w_cand_hi  = w_sync[r_cand];
  assign w_cnt_done = (r_cnt == CNT_END);

  // State register.
  always_ff @(posedge CLK) begin
    if (!RST) r_state <= KP_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next-state decode: debounce press/release of the single locked candidate.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      KP_IDLE: begin
        if (|w_sync) w_state_nxt = KP_PRESS_DEB;
      end
      KP_PRESS_DEB: begin
        if (!w_cand_hi)      w_state_nxt = KP_IDLE;
        else if (w_cnt_done) w_state_nxt = KP_HELD;
      end
      KP_HELD: begin
        if (!w_cand_hi) w_state_nxt = KP_REL_DEB;
      end
      KP_REL_DEB: begin
        if (w_cand_hi)       w_state_nxt = KP_HELD;
        else if (w_cnt_done) w_state_nxt = KP_IDLE;
      end
      default: w_state_nxt = KP_IDLE;
    endcase
  end

  // Output decode: press acceptance, combined fire strobe, held indication.
  always_comb begin
    w_fire_press = (r_state == KP_PRESS_DEB) && w_cand_hi && w_cnt_done;
    w_fire       = w_fire_press || w_fire_rep;
    w_held       = (r_state == KP_HELD) || (r_state == KP_REL_DEB);
  end

  // Candidate latch and saturating stability counter.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_cnt  <= '0;
      r_cand <= '0;
    end else begin
      unique case (r_state)
        KP_IDLE: begin
          if (|w_sync) begin
            r_cand <= w_sel;
            r_cnt  <= W_CNT'(1);
          end
        end
        KP_PRESS_DEB: begin
          if (w_cand_hi && !w_cnt_done) r_cnt <= r_cnt + W_CNT'(1);
        end
        KP_HELD: begin
          if (!w_cand_hi) r_cnt <= W_CNT'(1);
        end
        KP_REL_DEB: begin
          if (!w_cand_hi && !w_cnt_done) r_cnt <= r_cnt + W_CNT'(1);
        end
        default: r_cnt <= '0;
      endcase
    end
  end

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned W_REP   = (REP_MAX > 1) ? $clog2(REP_MAX) : 1;
  localparam logic [W_REP-1:0] DELAY_END  = W_REP'(REPEAT_DELAY - 1);
  localparam logic [W_REP-1:0] PERIOD_END = W_REP'(REPEAT_PERIOD - 1);

  logic [W_REP-1:0] r_rep;
  logic             r_rep_first;
  logic             w_rep_tick;
  logic             w_rep_hit;

  // Only HELD cycles with the key still down advance the repeat timer, so a
  // release bounce through REL_DEB pauses it without losing progress.
  assign w_rep_tick = (r_state == KP_HELD) && w_cand_hi;
  assign w_rep_hit  = (r_rep == (r_rep_first ? DELAY_END : PERIOD_END));
  assign w_fire_rep = w_rep_tick && w_rep_hit && (r_cand < KEY_ENTER);

  // Repeat timer: restarts at the accepted press, clears once the release completes.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_rep       <= '0;
      r_rep_first <= 1'b1;
    end else if (w_fire_press) begin
      r_rep       <= '0;
      r_rep_first <= 1'b1;
    end else if (w_rep_tick) begin
      if (w_rep_hit) begin
        r_rep       <= '0;
        r_rep_first <= 1'b0;
      end else begin
        r_rep <= r_rep + W_REP'(1);
      end
    end else if ((r_state == KP_REL_DEB) && (w_state_nxt == KP_IDLE)) begin
      r_rep       <= '0;
      r_rep_first <= 1'b1;
    end
  end
`else
  assign w_fire_rep = 1'b0;
`endif

  // Registered pulse and code; code holds until the next accepted pulse.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_pulse <= '0;
      r_code  <= '0;
    end else begin
      r_pulse <= w_fire ? (NUM_KEYS'(1) << r_cand) : '0;
      if (w_fire) r_code <= r_cand;
    end
  end

  assign key_pulse = r_pulse;
  assign key_valid = |r_pulse;
  assign key_code  = r_code;
  assign key_held  = w_held;

endmodule

// File: tb/tb_keypad_pulse_encoder.sv
// Self-checking bench for keypad_pulse_encoder: directed scenarios plus
// randomized key activity, compared every cycle against a streak-counting model.
module tb_keypad_pulse_encoder;

  localparam int D  = 4;
  localparam int RD = 20;
  localparam int RP = 8;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam bit AUTOREP = 1'b1;
`else
  localparam bit AUTOREP = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [11:0] key_raw = '0;
  logic [11:0] key_pulse;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_held;

  int n_tests = 0;
  int n_fail  = 0;

  keypad_pulse_encoder #(
    .DEBOUNCE_CYCLES (D),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .key_raw   (key_raw),
    .key_pulse (key_pulse),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_held  (key_held)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: raw levels pass a two-sample delay; a key is accepted after
  // D+1 consecutive high samples and released after D+1 consecutive low samples.
  logic [11:0] m_s1 = '0, m_s2 = '0;
  int          m_phase = 0;   // 0 free, 1 qualifying press, 2 owned
  int          m_key = 0, m_hi = 0, m_lo = 0, m_ticks = 0;
  logic [11:0] m_pulse = '0;
  logic [3:0]  m_code = '0;

  task automatic model_edge(input logic rst_n, input logic [11:0] raw);
    logic [11:0] sv, lsb;
    sv      = m_s2;
    m_pulse = '0;
    if (!rst_n) begin
      m_s1 = '0; m_s2 = '0; m_phase = 0; m_code = '0;
      m_hi = 0; m_lo = 0; m_ticks = 0;
      return;
    end
    case (m_phase)
      0: if (sv != 0) begin
        lsb     = sv & (~sv + 12'd1);
        m_key   = $clog2(lsb);
        m_hi    = 1;
        m_phase = 1;
      end
      1: if (sv[m_key]) begin
        m_hi++;
        if (m_hi == D + 1) begin
          m_pulse = 12'(1) << m_key;
          m_code  = 4'(m_key);
          m_phase = 2; m_lo = 0; m_ticks = 0;
        end
      end else m_phase = 0;
      default: if (sv[m_key]) begin
        if (m_lo == 0) begin
          m_ticks++;
          if (AUTOREP && m_key < 10 &&
              (m_ticks == RD || (m_ticks > RD && (m_ticks - RD) % RP == 0))) begin
            m_pulse = 12'(1) << m_key;
            m_code  = 4'(m_key);
          end
        end
        m_lo = 0;
      end else begin
        m_lo++;
        if (m_lo == D + 1) m_phase = 0;
      end
    endcase
    m_s2 = m_s1;
    m_s1 = raw;
  endtask

  // Per-scenario observation of the DUT's pulses.
  int          sc_edges, sc_pulses;
  int          sc_at[16];
  logic [11:0] sc_val[16];
  logic [3:0]  sc_code[16];

  task automatic start_sc();
    sc_edges = 0; sc_pulses = 0;
    for (int i = 0; i < 16; i++) begin
      sc_at[i] = -1; sc_val[i] = '0; sc_code[i] = '0;
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    model_edge(RST, key_raw);
    #1;
    check("pulse", 32'(key_pulse), 32'(m_pulse));
    check("valid", 32'(key_valid), 32'(|m_pulse));
    check("code",  32'(key_code),  32'(m_code));
    check("held",  32'(key_held),  32'(m_phase == 2));
    sc_edges++;
    if (key_pulse != '0) begin
      if (sc_pulses < 16) begin
        sc_at[sc_pulses]   = sc_edges;
        sc_val[sc_pulses]  = key_pulse;
        sc_code[sc_pulses] = key_code;
      end
      sc_pulses++;
    end
  endtask

  task automatic run(input logic [11:0] raw, input int n);
    key_raw = raw;
    repeat (n) tick();
  endtask

  initial begin
    int len, kind;
    logic [11:0] base;
    start_sc();
    RST = 1'b0;
    run(12'h000, 3);
    RST = 1'b1;
    run(12'h000, 3);

    // Clean press of digit 7.
    start_sc();
    run(12'h080, 30);
    run(12'h000, 20);
    check("t1_count", 32'(sc_pulses), AUTOREP ? 32'd2 : 32'd1);
    check("t1_edge",  32'(sc_at[0]), 32'(D + 3));
    check("t1_val",   32'(sc_val[0]), 32'h080);
    check("t1_code",  32'(sc_code[0]), 32'd7);

    // Short glitch on digit 3.
    start_sc();
    run(12'h008, 3);
    run(12'h000, 15);
    check("t2_count", 32'(sc_pulses), 32'd0);

    // Digit 5 with bouncing release.
    start_sc();
    run(12'h020, 15);
    for (int i = 0; i < 5; i++) begin
      run(12'h000, 1);
      run(12'h020, 1);
    end
    run(12'h000, 20);
    check("t3_count", 32'(sc_pulses), 32'd1);
    check("t3_val",   32'(sc_val[0]), 32'h020);

    // Simultaneous 2 and 9: lowest wins, 9 follows after full release + press.
    start_sc();
    run(12'h204, 15);
    check("t4a_count", 32'(sc_pulses), 32'd1);
    check("t4a_edge",  32'(sc_at[0]), 32'(D + 3));
    check("t4a_val",   32'(sc_val[0]), 32'h004);
    start_sc();
    run(12'h200, 16);
    run(12'h000, 20);
    check("t4b_count", 32'(sc_pulses), 32'd1);
    check("t4b_edge",  32'(sc_at[0]), 32'(2 * D + 4));
    check("t4b_val",   32'(sc_val[0]), 32'h200);
    check("t4b_code",  32'(sc_code[0]), 32'd9);

    // Reset during press debounce of ENTER.
    start_sc();
    run(12'h400, 4);
    RST = 1'b0;
    tick();
    check("t5_rst_code",  32'(key_code), 32'd0);
    check("t5_rst_held",  32'(key_held), 32'd0);
    check("t5_rst_pulse", 32'(key_pulse), 32'd0);
    check("t5_pre_count", 32'(sc_pulses), 32'd0);
    RST = 1'b1;
    start_sc();
    run(12'h400, 20);
    run(12'h000, 20);
    check("t5_count", 32'(sc_pulses), 32'd1);
    check("t5_edge",  32'(sc_at[0]), 32'(D + 3));
    check("t5_val",   32'(sc_val[0]), 32'h400);

`ifdef KEYPAD_AUTOREPEAT_EN
    // Auto-repeat on digit 1, none on ENTER.
    begin
      int gaps[6];
      gaps = '{0, 20, 28, 36, 44, 52};
      start_sc();
      run(12'h002, 60);
      run(12'h000, 20);
      check("t6_count", 32'(sc_pulses), 32'd6);
      for (int i = 1; i < 6; i++) check("t6_gap", 32'(sc_at[i] - sc_at[0]), 32'(gaps[i]));
      start_sc();
      run(12'h400, 60);
      run(12'h000, 20);
      check("t6_enter_count", 32'(sc_pulses), 32'd1);
    end
`endif

    // Randomized activity, checked cycle by cycle against the model.
    for (int s = 0; s < 300; s++) begin
      kind = $urandom_range(0, 9);
      len  = ($urandom_range(0, 9) == 0) ? $urandom_range(30, 60) : $urandom_range(1, 30);
      case (kind)
        0, 1, 2:    base = '0;
        3, 4, 5, 6: base = 12'(1) << $urandom_range(0, 11);
        7, 8:       base = 12'($urandom);
        default:    base = 12'(1) << $urandom_range(0, 11);
      endcase
      for (int c = 0; c < len; c++) begin
        if (kind == 9 && $urandom_range(0, 3) == 0) key_raw = '0;
        else key_raw = base;
        tick();
      end
      if ($urandom_range(0, 24) == 0) begin
        RST = 1'b0;
        repeat ($urandom_range(1, 2)) tick();
        RST = 1'b1;
      end
    end
    run(12'h000, 20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
